// File: rtl/load_store_unit_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
// Store funct3 values alias the matching load sizes (SB=LB, SH=LH, SW=LW).
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10,
      ST_FAULT  = 2'b11
   } lsu_state_t;

   typedef enum logic [1:0] {
      LSU_OK         = 2'b00,
      LSU_MISALIGNED = 2'b01,
      LSU_ILLEGAL    = 2'b10,
      LSU_TIMEOUT    = 2'b11
   } lsu_cause_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: byte enables, store replication, request checks
// and load extraction/extension from the latched funct3 and offset.
module lsu_data_align
   import load_store_unit_pkg::*;
(
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [1:0]  req_offset,
   input  logic [31:0] req_wdata,
   output logic [3:0]  req_be,
   output logic [31:0] req_wdata_rep,
   output logic        req_misaligned,
   output logic        req_illegal,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  lane [4];
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = ld_word[8*gi +: 8];
      end
   endgenerate

   assign ld_byte = lane[ld_offset];
   assign ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];

   always_comb begin
      req_be         = 4'b0000;
      req_wdata_rep  = req_wdata;
      req_misaligned = 1'b0;
      req_illegal    = 1'b0;
      case (req_funct3)
         F3_LB, F3_LBU: begin
            req_be        = 4'b0001 << req_offset;
            req_wdata_rep = {4{req_wdata[7:0]}};
            req_illegal   = req_write && (req_funct3 == F3_LBU);
         end
         F3_LH, F3_LHU: begin
            req_be         = req_offset[1] ? 4'b1100 : 4'b0011;
            req_wdata_rep  = {2{req_wdata[15:0]}};
            req_misaligned = req_offset[0];
            req_illegal    = req_write && (req_funct3 == F3_LHU);
         end
         F3_LW: begin
            req_be         = 4'b1111;
            req_misaligned = (req_offset != 2'b00);
         end
         default: req_illegal = 1'b1;
      endcase
   end

   always_comb begin
      ld_data = 32'h0;
      case (ld_funct3)
         F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_LBU:  ld_data = {24'h0, ld_byte};
         F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         F3_LHU:  ld_data = {16'h0, ld_half};
         F3_LW:   ld_data = ld_word;
         default: ld_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store, drives a held memory request
// and returns a single-cycle response; faulting requests never reach memory.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_cause,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_t        state_reg, state_next;
   lsu_cause_t        cause_reg, cause_next;
   logic              write_reg;
   logic [2:0]        funct3_reg;
   logic [1:0]        offset_reg;
   logic [31:0]       addr_reg;
   logic [3:0]        be_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       rdata_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic [3:0]  req_be;
   logic [31:0] req_wdata_rep;
   logic        req_misaligned;
   logic        req_illegal;
   logic [31:0] ld_data;

   lsu_data_align u_align (
      .req_write      (req_write),
      .req_funct3     (req_funct3),
      .req_offset     (req_addr[1:0]),
      .req_wdata      (req_wdata),
      .req_be         (req_be),
      .req_wdata_rep  (req_wdata_rep),
      .req_misaligned (req_misaligned),
      .req_illegal    (req_illegal),
      .ld_funct3      (funct3_reg),
      .ld_offset      (offset_reg),
      .ld_word        (mem_rdata),
      .ld_data        (ld_data)
   );

   always_comb begin
      state_next = state_reg;
      cause_next = cause_reg;
      req_ready  = 1'b0;
      mem_req    = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'h0;
      resp_cause = LSU_OK;
      case (state_reg)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               // Illegal funct3 outranks the alignment check, which is meaningless for it.
               if (req_illegal) begin
                  state_next = ST_FAULT;
                  cause_next = LSU_ILLEGAL;
               end else if (req_misaligned) begin
                  state_next = ST_FAULT;
                  cause_next = LSU_MISALIGNED;
               end else begin
                  state_next = ST_ACCESS;
                  cause_next = LSU_OK;
               end
            end
         end
         ST_ACCESS: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               state_next = ST_RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST)) begin
               state_next = ST_FAULT;
               cause_next = LSU_TIMEOUT;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_reg;
            state_next = ST_IDLE;
         end
         ST_FAULT: begin
            resp_valid = 1'b1;
            resp_cause = cause_reg;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Gated by reset so the core is released the moment reset asserts.
   assign stall     = ~reset & (((state_reg == ST_IDLE) & req_valid) | (state_reg == ST_ACCESS));
   assign mem_we    = (state_reg == ST_ACCESS) & write_reg;
   assign mem_addr  = addr_reg;
   assign mem_be    = be_reg;
   assign mem_wdata = wdata_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         cause_reg  <= LSU_OK;
         write_reg  <= 1'b0;
         funct3_reg <= 3'b000;
         offset_reg <= 2'b00;
         addr_reg   <= 32'h0;
         be_reg     <= 4'b0000;
         wdata_reg  <= 32'h0;
         rdata_reg  <= 32'h0;
         cnt_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cause_reg <= cause_next;
         if ((state_reg == ST_IDLE) && req_valid) begin
            write_reg  <= req_write;
            funct3_reg <= req_funct3;
            offset_reg <= req_addr[1:0];
            addr_reg   <= {req_addr[31:2], 2'b00};
            be_reg     <= req_be;
            wdata_reg  <= req_wdata_rep;
         end
         cnt_reg <= (state_reg == ST_ACCESS) ? cnt_reg + CNT_W'(1) : '0;
         if ((state_reg == ST_ACCESS) && mem_ack) begin
            rdata_reg <= write_reg ? 32'h0 : ld_data;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses are queued at issue
// and popped when the unit raises resp_valid.
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_cause;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  cause;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_cause (resp_cause),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
   endtask

   // Response expected in the current cycle; afterwards the unit must be idle again.
   task automatic check_resp(input string tag);
      exp_t e;
      @(negedge clk);
      check({tag, ".resp_valid"}, resp_valid, 1);
      check({tag, ".stall_low"}, stall, 0);
      check({tag, ".mem_req_low"}, mem_req, 0);
      check({tag, ".pending"}, (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, ".rdata"}, resp_rdata, e.rdata);
         check({tag, ".cause"}, resp_cause, e.cause);
      end
      $display("txn %s rdata=%h cause=%0d", tag, resp_rdata, resp_cause);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, ".resp_pulse"}, resp_valid, 0);
      check({tag, ".ready_again"}, req_ready, 1);
   endtask

   task automatic mem_op(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_cycle,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
      exp_t e;
      drive_req(wr, f3, addr, wdata);
      @(negedge clk);
      check({tag, ".req_ready"}, req_ready, 1);
      check({tag, ".stall_req"}, stall, 1);
      e.rdata = wr ? 32'h0 : exp_rdata;
      e.cause = 2'b00;
      sb_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 1; i <= ack_cycle; i++) begin
         @(negedge clk);
         check({tag, ".mem_req"}, mem_req, 1);
         check({tag, ".stall_access"}, stall, 1);
         if (i == 1) begin
            check({tag, ".mem_addr"}, mem_addr, exp_addr);
            check({tag, ".mem_be"}, mem_be, exp_be);
            check({tag, ".mem_we"}, mem_we, wr);
            check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
         end
         if (i == ack_cycle) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      check_resp(tag);
   endtask

   task automatic fault_op(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] exp_cause);
      exp_t e;
      drive_req(wr, f3, addr, 32'h1234_5678);
      @(negedge clk);
      check({tag, ".stall_req"}, stall, 1);
      e.rdata = 32'h0;
      e.cause = exp_cause;
      sb_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_resp(tag);
   endtask

   initial begin
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_ack    = 1'b0;
      mem_rdata  = 32'h0;
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst.req_ready", req_ready, 1);
      check("rst.stall", stall, 0);
      check("rst.mem_req", mem_req, 0);
      check("rst.resp_valid", resp_valid, 0);
      check("rst.mem_addr", mem_addr, 32'h0);
      check("rst.mem_be", mem_be, 4'h0);
      reset = 1'b0;

      mem_op("sw",  1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3,
             32'h100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
      mem_op("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1,
             32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80);
      mem_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 2,
             32'h100, 4'b1000, 32'h0, 32'h0000_0080);
      mem_op("sh",  1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 1,
             32'h100, 4'b1100, 32'hABCD_ABCD, 32'h0);
      mem_op("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'hABCD_0000, 1,
             32'h100, 4'b1100, 32'h0, 32'h0000_ABCD);
      mem_op("lh",  1'b0, 3'b001, 32'h100, 32'h0, 32'h0000_8001, 2,
             32'h100, 4'b0011, 32'h0, 32'hFFFF_8001);
      mem_op("sb",  1'b1, 3'b000, 32'h201, 32'h0000_005A, 32'h0, 1,
             32'h200, 4'b0010, 32'h5A5A_5A5A, 32'h0);

      fault_op("lw_mis",  1'b0, 3'b010, 32'h101, 2'b01);
      fault_op("f3_011",  1'b0, 3'b011, 32'h100, 2'b10);
      fault_op("sbu_ill", 1'b1, 3'b100, 32'h100, 2'b10);
      fault_op("sh_mis",  1'b1, 3'b001, 32'h103, 2'b01);

      // Timeout: four request cycles, fault response, late ack ignored.
      begin
         exp_t e;
         drive_req(1'b0, 3'b010, 32'h400, 32'h0);
         e.rdata = 32'h0;
         e.cause = 2'b11;
         sb_q.push_back(e);
         @(posedge clk); #1;
         req_valid = 1'b0;
         for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("tmo.mem_req", mem_req, 1);
            @(posedge clk); #1;
         end
         check_resp("tmo");
         mem_ack   = 1'b1;
         mem_rdata = 32'hCAFE_F00D;
         @(posedge clk); #1;
         mem_ack = 1'b0;
         @(negedge clk);
         check("tmo.late_ack_resp", resp_valid, 0);
         check("tmo.late_ack_ready", req_ready, 1);
         check("tmo.late_ack_req", mem_req, 0);
      end

      // Reset mid-access: outputs drop immediately, a stale ack is dropped.
      drive_req(1'b0, 3'b010, 32'h300, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rstacc.mem_req_c1", mem_req, 1);
      @(posedge clk); #2;
      check("rstacc.mem_req_c2", mem_req, 1);
      reset = 1'b1;
      #1;
      check("rstacc.mem_req_drop", mem_req, 0);
      check("rstacc.stall_drop", stall, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rstacc.ready", req_ready, 1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1111_2222;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rstacc.no_resp", resp_valid, 0);
         check("rstacc.idle_req", mem_req, 0);
      end
      $display("txn rst_mid_access dropped");

      mem_op("lw_after_rst", 1'b0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 1,
             32'h200, 4'b1111, 32'h0, 32'h1234_5678);

      check("sb.drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
